// File: rtl/hood_mode_fsm_pkg.sv
// Shared codes, state encoding and default durations for the hood mode controller.
package hood_mode_fsm_pkg;

   localparam int unsigned DEF_HURRICANE_SEC = 60;
   localparam int unsigned DEF_EXIT_SEC      = 60;
   localparam int unsigned DEF_CLEAN_SEC     = 180;
   localparam int unsigned DEF_CNT_W         = 8;
   localparam int unsigned MODE_W            = 3;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_STANDBY   = 3'd1,
      ST_MENU      = 3'd2,
      ST_LVL1      = 3'd3,
      ST_LVL2      = 3'd4,
      ST_LVL3      = 3'd5,
      ST_LVL3_EXIT = 3'd6,
      ST_CLEAN     = 3'd7
   } hood_state_e;

   localparam logic [MODE_W-1:0] MODE_STANDBY = 3'b000;
   localparam logic [MODE_W-1:0] MODE_L1      = 3'b001;
   localparam logic [MODE_W-1:0] MODE_L2      = 3'b010;
   localparam logic [MODE_W-1:0] MODE_L3      = 3'b011;
   localparam logic [MODE_W-1:0] MODE_CLEAN   = 3'b100;

   // Externally visible mode code for a controller state; the exit delay still shows level 3.
   function automatic logic [MODE_W-1:0] state_to_mode(input hood_state_e s);
      logic [MODE_W-1:0] m;
      m = MODE_STANDBY;
      case (s)
         ST_LVL1:      m = MODE_L1;
         ST_LVL2:      m = MODE_L2;
         ST_LVL3:      m = MODE_L3;
         ST_LVL3_EXIT: m = MODE_L3;
         ST_CLEAN:     m = MODE_CLEAN;
         default:      m = MODE_STANDBY;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/hood_mode_fsm_sec_countdown.sv
// Seconds countdown: load, clear, tick-driven decrement that saturates at zero.
module sec_countdown #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick_en,
   output logic [CNT_W-1:0] count,
   output logic             expire
);

   logic [CNT_W-1:0] count_q;

   // Final tick of a timed interval (combinational, consumed by the FSM next-state logic).
   assign expire = tick_en && (count_q == CNT_W'(1));
   assign count  = count_q;

   // Count register: clear beats load beats decrement; never wraps below zero.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (tick_en && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/hood_mode_fsm.sv
// Range-hood operating-mode controller: menu rules, hurricane limit, delayed exit, self-clean.
module hood_mode_fsm
   import hood_mode_fsm_pkg::*;
#(
   parameter int unsigned HURRICANE_SEC = DEF_HURRICANE_SEC,
   parameter int unsigned EXIT_SEC      = DEF_EXIT_SEC,
   parameter int unsigned CLEAN_SEC     = DEF_CLEAN_SEC,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_1hz,
   input  logic              machine_state,
   input  logic              menu_pulse,
   input  logic              mode1_pulse,
   input  logic              mode2_pulse,
   input  logic              mode3_pulse,
   input  logic              clean_pulse,
   output logic [MODE_W-1:0] mode_state,
   output logic              menu_active,
   output logic [CNT_W-1:0]  countdown,
   output logic              mode3_used,
   output logic              clean_done
);

   hood_state_e       state_q, state_d;
   logic [MODE_W-1:0] mode_state_q;
   logic              menu_active_q;
   logic              mode3_used_q, mode3_used_d;
   logic              clean_done_q, clean_done_d;

   logic              cd_clear, cd_load, cd_tick_c, cd_expire;
   logic [CNT_W-1:0]  cd_val, cd_count;

   // Ticks count only in timed states; a menu press in LVL3 takes the cycle and discards the tick.
   assign cd_tick_c = tick_1hz && machine_state &&
                      (((state_q == ST_LVL3) && !menu_pulse) ||
                       (state_q == ST_LVL3_EXIT) || (state_q == ST_CLEAN));

   sec_countdown #(.CNT_W(CNT_W)) u_cd (
      .clk      (clk),
      .reset    (reset),
      .clear    (cd_clear),
      .load     (cd_load),
      .load_val (cd_val),
      .tick_en  (cd_tick_c),
      .count    (cd_count),
      .expire   (cd_expire)
   );

   // Next-state and countdown control; power-off dominates, buttons resolved by priority chain.
   always_comb begin
      state_d      = state_q;
      cd_clear     = 1'b0;
      cd_load      = 1'b0;
      cd_val       = '0;
      mode3_used_d = mode3_used_q;
      clean_done_d = 1'b0;

      if (!machine_state) begin
         state_d      = ST_OFF;
         cd_clear     = 1'b1;
         mode3_used_d = 1'b0;
      end else begin
         case (state_q)
            ST_OFF: state_d = ST_STANDBY;
            ST_STANDBY: begin
               if (menu_pulse) state_d = ST_MENU;
            end
            ST_MENU: begin
               if (menu_pulse) begin
                  state_d = ST_STANDBY;
               end else if (clean_pulse) begin
                  state_d = ST_CLEAN;
                  cd_load = 1'b1;
                  cd_val  = CNT_W'(CLEAN_SEC);
               end else if (mode3_pulse && !mode3_used_q) begin
                  state_d      = ST_LVL3;
                  cd_load      = 1'b1;
                  cd_val       = CNT_W'(HURRICANE_SEC);
                  mode3_used_d = 1'b1;
               end else if (mode2_pulse) begin
                  state_d = ST_LVL2;
               end else if (mode1_pulse) begin
                  state_d = ST_LVL1;
               end
            end
            ST_LVL1, ST_LVL2: begin
               if (menu_pulse)       state_d = ST_STANDBY;
               else if (mode2_pulse) state_d = ST_LVL2;
               else if (mode1_pulse) state_d = ST_LVL1;
            end
            ST_LVL3: begin
               if (menu_pulse) begin
                  state_d = ST_LVL3_EXIT;
                  cd_load = 1'b1;
                  cd_val  = CNT_W'(EXIT_SEC);
               end else if (cd_expire) begin
                  state_d = ST_LVL2;
               end
            end
            ST_LVL3_EXIT: begin
               if (cd_expire) state_d = ST_STANDBY;
            end
            ST_CLEAN: begin
               if (cd_expire) begin
                  state_d      = ST_STANDBY;
                  clean_done_d = 1'b1;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // State and registered outputs, all derived from the next-state values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_OFF;
         mode_state_q  <= MODE_STANDBY;
         menu_active_q <= 1'b0;
         mode3_used_q  <= 1'b0;
         clean_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_state_q  <= state_to_mode(state_d);
         menu_active_q <= (state_d == ST_MENU);
         mode3_used_q  <= mode3_used_d;
         clean_done_q  <= clean_done_d;
      end
   end

   assign mode_state  = mode_state_q;
   assign menu_active = menu_active_q;
   assign countdown   = cd_count;
   assign mode3_used  = mode3_used_q;
   assign clean_done  = clean_done_q;

endmodule

// File: tb/tb_hood_mode_fsm.sv
// Self-checking bench for hood_mode_fsm: directed scenarios plus randomized traffic vs a behavioural model.
module tb_hood_mode_fsm;

   localparam int unsigned HUR = 3;
   localparam int unsigned EXT = 2;
   localparam int unsigned CLN = 4;
   localparam int unsigned CW  = 8;

   logic          clk = 1'b0;
   logic          reset, tick_1hz, machine_state;
   logic          menu_pulse, mode1_pulse, mode2_pulse, mode3_pulse, clean_pulse;
   logic [2:0]    mode_state;
   logic          menu_active, mode3_used, clean_done;
   logic [CW-1:0] countdown;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   hood_mode_fsm #(
      .HURRICANE_SEC(HUR), .EXIT_SEC(EXT), .CLEAN_SEC(CLN), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .machine_state(machine_state),
      .menu_pulse(menu_pulse), .mode1_pulse(mode1_pulse), .mode2_pulse(mode2_pulse),
      .mode3_pulse(mode3_pulse), .clean_pulse(clean_pulse),
      .mode_state(mode_state), .menu_active(menu_active), .countdown(countdown),
      .mode3_used(mode3_used), .clean_done(clean_done)
   );

   // Behavioural model: named modes, integer seconds left, hurricane-used flag.
   typedef enum int {M_OFF, M_STBY, M_MENU, M_L1, M_L2, M_L3, M_EXIT, M_CLEAN} mmode_t;
   mmode_t m_st   = M_OFF;
   int     m_cnt  = 0;
   bit     m_used = 1'b0;
   bit     m_done = 1'b0;

   // Button index order is priority order: 0 menu, 1 clean, 2 mode3, 3 mode2, 4 mode1.
   function automatic bit legal(input mmode_t s, input int b, input bit used);
      case (s)
         M_STBY:      return b == 0;
         M_MENU:      return (b != 2) || !used;
         M_L1, M_L2:  return (b == 0) || (b == 3) || (b == 4);
         M_L3:        return b == 0;
         default:     return 1'b0;
      endcase
   endfunction

   function automatic int exp_mode(input mmode_t s);
      case (s)
         M_L1:           return 1;
         M_L2:           return 2;
         M_L3, M_EXIT:   return 3;
         M_CLEAN:        return 4;
         default:        return 0;
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit ms, input bit pressed[5], input bit tk);
      int act;
      m_done = 1'b0;
      if (rst || !ms) begin
         m_st = M_OFF; m_cnt = 0; m_used = 1'b0;
         return;
      end
      if (m_st == M_OFF) begin
         m_st = M_STBY;
         return;
      end
      act = -1;
      for (int b = 0; b < 5; b++)
         if (act < 0 && pressed[b] && legal(m_st, b, m_used)) act = b;
      if (act >= 0) begin
         case (m_st)
            M_STBY: m_st = M_MENU;
            M_MENU: begin
               case (act)
                  0: m_st = M_STBY;
                  1: begin m_st = M_CLEAN; m_cnt = CLN; end
                  2: begin m_st = M_L3; m_cnt = HUR; m_used = 1'b1; end
                  3: m_st = M_L2;
                  default: m_st = M_L1;
               endcase
            end
            M_L1, M_L2: m_st = (act == 0) ? M_STBY : (act == 3) ? M_L2 : M_L1;
            M_L3: begin m_st = M_EXIT; m_cnt = EXT; end
            default: ;
         endcase
      end else if (tk && m_cnt > 0) begin
         if (m_cnt == 1) begin
            m_cnt = 0;
            if (m_st == M_L3) m_st = M_L2;
            else begin
               if (m_st == M_CLEAN) m_done = 1'b1;
               m_st = M_STBY;
            end
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // One clock: drive inputs, advance model, sample #1 after the edge and compare every output.
   task automatic step(input bit rst, input bit ms, input bit mn, input bit cl,
                       input bit m3, input bit m2, input bit m1, input bit tk);
      bit pressed[5];
      reset = rst; machine_state = ms; tick_1hz = tk;
      menu_pulse = mn; clean_pulse = cl; mode3_pulse = m3; mode2_pulse = m2; mode1_pulse = m1;
      pressed[0] = mn; pressed[1] = cl; pressed[2] = m3; pressed[3] = m2; pressed[4] = m1;
      @(posedge clk);
      model_step(rst, ms, pressed, tk);
      #1;
      check("mode_state",  32'(mode_state),  32'(exp_mode(m_st)));
      check("menu_active", 32'(menu_active), 32'(m_st == M_MENU));
      check("countdown",   32'(countdown),   32'(m_cnt));
      check("mode3_used",  32'(mode3_used),  32'(m_used));
      check("clean_done",  32'(clean_done),  32'(m_done));
   endtask

   initial begin
      // Reset and power-up.
      step(1,0, 0,0,0,0,0, 0);
      check("rst_mode", 32'(mode_state), 32'd0);
      check("rst_cnt",  32'(countdown),  32'd0);
      step(0,1, 0,0,0,0,0, 0);
      check("pwr_stby", 32'(mode_state), 32'd0);
      step(0,1, 1,0,0,0,0, 0);
      check("menu_on", 32'(menu_active), 32'd1);
      step(0,1, 0,0,0,1,0, 0);
      check("l2_mode", 32'(mode_state), 32'd2);
      check("menu_off", 32'(menu_active), 32'd0);

      // Hurricane runs HUR ticks then drops to level 2; second entry refused.
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 0,0,1,0,0, 0);
      check("l3_mode", 32'(mode_state), 32'd3);
      check("l3_cnt",  32'(countdown),  32'(HUR));
      step(0,1, 0,0,0,0,0, 1);
      step(0,1, 0,0,0,0,0, 1);
      check("l3_cnt1", 32'(countdown), 32'd1);
      step(0,1, 0,0,0,0,0, 1);
      check("l3_drop", 32'(mode_state), 32'd2);
      check("l3_used", 32'(mode3_used), 32'd1);
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 0,0,1,0,0, 0);
      check("l3_refused", 32'(menu_active), 32'd1);

      // Fresh power cycle; menu plus tick in LVL3 loads the exit delay undecremented.
      step(0,0, 0,0,0,0,0, 0);
      step(0,1, 0,0,0,0,0, 0);
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 0,0,1,0,0, 0);
      step(0,1, 1,0,0,0,0, 1);
      check("exit_cnt",  32'(countdown),  32'(EXT));
      check("exit_mode", 32'(mode_state), 32'd3);
      step(0,1, 0,0,0,0,0, 1);
      step(0,1, 0,0,0,0,0, 1);
      check("exit_done", 32'(mode_state), 32'd0);

      // Self-clean ignores buttons and pulses clean_done on the last tick.
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 0,1,0,0,0, 0);
      check("cln_mode", 32'(mode_state), 32'd4);
      step(0,1, 0,0,0,0,1, 1);
      step(0,1, 0,0,0,0,0, 1);
      step(0,1, 0,0,0,0,0, 1);
      step(0,1, 0,0,0,0,0, 1);
      check("cln_done", 32'(clean_done), 32'd1);
      check("cln_stby", 32'(mode_state), 32'd0);
      step(0,1, 0,0,0,0,0, 0);
      check("cln_done_1cyc", 32'(clean_done), 32'd0);

      // Power drop mid-clean aborts with no done pulse and clears the hurricane flag.
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 0,1,0,0,0, 0);
      step(0,1, 0,0,0,0,0, 1);
      step(0,1, 0,0,0,0,0, 1);
      step(0,0, 0,0,0,0,0, 1);
      check("pd_cnt",  32'(countdown),  32'd0);
      check("pd_used", 32'(mode3_used), 32'd0);
      check("pd_done", 32'(clean_done), 32'd0);

      // Menu outranks every other pulse in MENU.
      step(0,1, 0,0,0,0,0, 0);
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 1,0,1,0,1, 0);
      check("menu_wins", 32'(menu_active), 32'd0);

      // Reset mid-clean aborts without a done pulse.
      step(0,1, 1,0,0,0,0, 0);
      step(0,1, 0,1,0,0,0, 0);
      step(0,1, 0,0,0,0,0, 1);
      step(1,1, 0,0,0,0,0, 1);
      check("rst_abort", 32'(clean_done), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 99) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hood_mode_fsm.md
# hood_mode_fsm

Range-hood operating-mode controller sitting directly downstream of the power on/off control. Consumes its `machine_state` level plus single-cycle button pulses and a 1 Hz tick. Produces the 3-bit `mode_state` and the seconds-remaining value consumed by the timer/display path. Enforces the menu entry rules, the once-per-power-cycle hurricane limit, the delayed-exit rule and the self-clean duration.

## Interface
- `HURRICANE_SEC`, 60: level-3 run time before automatic drop to level 2; must be ≥1.
- `EXIT_SEC`, 60: delay from menu press in level 3 to standby; must be ≥1.
- `CLEAN_SEC`, 180: self-clean duration; must be ≥1.
- `CNT_W`, 8: countdown width; must hold the largest of the three values.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset is synchronous and active-high. One clock.
- `tick_1hz` in 1: one-cycle pulse, once per second.
- `machine_state` in 1: power level; 1 = on.
- `menu_pulse`, `mode1_pulse`, `mode2_pulse`, `mode3_pulse`, `clean_pulse` in 1 each: debounced one-cycle button pulses.
- `mode_state` out 3: 000 standby/off, 001 level 1, 010 level 2, 011 level 3, 100 self-clean.
- `menu_active` out 1: high while in MENU.
- `countdown` out CNT_W: seconds remaining in a timed state; 0 otherwise.
- `mode3_used` out 1: hurricane already used in this power cycle.
- `clean_done` out 1: one-cycle pulse when self-clean completes.

## Operation
States: OFF, STANDBY, MENU, LVL1, LVL2, LVL3, LVL3_EXIT, CLEAN.

Power:
- `machine_state`=0 in any state → OFF on the next edge. Also clears `countdown` and `mode3_used`.
- OFF with `machine_state`=1 → STANDBY.

Button priority within a cycle: menu > clean > mode3 > mode2 > mode1. Only the highest-priority pulse that is legal in the current state acts; all others are dropped.

Per-state behaviour:
- STANDBY: menu → MENU. All other pulses are ignored.
- MENU:
  - menu → STANDBY.
  - mode1 → LVL1.
  - mode2 → LVL2.
  - mode3 → LVL3 only if `mode3_used`=0; loads HURRICANE_SEC and sets `mode3_used`. If `mode3_used`=1 the pulse is ignored and the block stays in MENU.
  - clean → CLEAN; loads CLEAN_SEC.
- LVL1/LVL2:
  - mode1/mode2 switch level.
  - menu → STANDBY immediately.
  - mode3 and clean are ignored.
- LVL3:
  - tick with `countdown`=1 → LVL2 and `countdown`←0.
  - Other ticks decrement `countdown`.
  - menu → LVL3_EXIT and loads EXIT_SEC.
  - mode1/mode2/mode3/clean are ignored.
- LVL3_EXIT:
  - `mode_state` stays 011.
  - Ticks decrement `countdown`; tick with `countdown`=1 → STANDBY.
  - All buttons are ignored.
- CLEAN:
  - All buttons are ignored.
  - Ticks decrement `countdown`; tick with `countdown`=1 → STANDBY and `clean_done`=1 for one cycle.

Boundary conditions:
- Button and tick in the same cycle: the button transition wins and the tick is discarded. A menu pulse in LVL3 therefore loads EXIT_SEC without decrementing first.
- Power-off overrides everything in the same cycle, including a tick or button.
- `countdown` never underflows; it is 0 outside LVL3, LVL3_EXIT and CLEAN.

## Timing
- All outputs are registered. Pulse or tick on edge N → new state and outputs visible after edge N.
- Reset values: state OFF, `mode_state`=000, `menu_active`=0, `countdown`=0, `mode3_used`=0, `clean_done`=0.
- Reset mid-countdown aborts it with no `clean_done` pulse.
- Timed durations:
  - Hurricane lasts exactly HURRICANE_SEC ticks after entry.
  - Exit lasts exactly EXIT_SEC ticks after the menu press.
  - Clean lasts exactly CLEAN_SEC ticks after entry.
- Release after reset: the first edge with `reset`=0 and `machine_state`=1 moves OFF → STANDBY.

## Structure
- Shared package holds:
  - state enum (3-bit);
  - `mode_state` codes MODE_STANDBY=000, MODE_L1=001, MODE_L2=010, MODE_L3=011, MODE_CLEAN=100;
  - default durations.
  - The display and timer blocks import the same codes.
- Sub-module `sec_countdown`: load value and load strobe, tick enable, clear; outputs `count` and `expire` (tick while count=1). It owns all decrement/underflow logic, and the FSM instantiates one.

## Test plan
- Reset, then `machine_state`=1 → STANDBY next cycle, `mode_state`=000. Then menu, mode2 → `menu_active` 1 then 0, `mode_state`=010.
- HURRICANE_SEC=3: menu, mode3 → `mode_state`=011, `countdown` 3,2,1 on ticks. Third tick → `mode_state`=010, `countdown`=0, `mode3_used`=1. Then menu, menu, mode3 → stays in MENU.
- EXIT_SEC=2: in LVL3, apply menu and tick in the same cycle → `countdown`=2 (no decrement), `mode_state`=011. After 2 ticks → 000.
- CLEAN_SEC=4: menu, clean → `mode_state`=100. mode1 pulses during clean are ignored. Fourth tick → `clean_done` for one cycle, `mode_state`=000.
- In CLEAN with `countdown`=2, drop `machine_state` → OFF next cycle, `countdown`=0, no `clean_done`, `mode3_used` cleared.
- In MENU, pulse menu+mode1+mode3 in the same cycle → STANDBY (menu wins).
